// File: rtl/fft_input_loader.sv
// fft_input_loader: collects N serial complex samples into parallel Re/Im
// frame arrays for the Butterfly, pulses start when a frame is complete,
// then holds the frame until the Butterfly reports fft_done.
// Optional build macro: FFT_IN_BITREV_EN -- when defined, samples are stored
// at the bit-reversed index of their arrival count (decimation-in-time order);
// when undefined, samples are stored in natural order.
module fft_input_loader #(
  parameter int N       = 64,
  parameter int LOG2N   = 6,
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] in_Re,
  input  logic [D_WIDTH-1:0] in_Im,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               fft_done,
  output logic [D_WIDTH-1:0] output_Re [N-1:0],
  output logic [D_WIDTH-1:0] output_Im [N-1:0],
  output logic               start
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    START,
    HOLD
  } state_t;

  state_t           state;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] wr_idx;
  logic             accept;

  // Storage index for the sample with arrival count k.
  function automatic logic [LOG2N-1:0] wr_index(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
`ifdef FFT_IN_BITREV_EN
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
`else
    r = k;
`endif
    return r;
  endfunction

  // Handshake and write address; in_ready is high exactly while in FILL.
  always_comb begin
    accept = in_valid && in_ready;
    wr_idx = wr_index(wr_cnt);
  end

  // Control FSM with registered in_ready/start; sample counter wraps on the Nth accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      in_ready <= 1'b0;
      start    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FILL;
          in_ready <= 1'b1;
          start    <= 1'b0;
        end
        FILL: begin
          start <= 1'b0;
          if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LOG2N'(N - 1)) begin
              state    <= START;
              in_ready <= 1'b0;
              start    <= 1'b1;
            end
          end
        end
        START: begin
          state    <= HOLD;
          start    <= 1'b0;
          in_ready <= 1'b0;
        end
        HOLD: begin
          start <= 1'b0;
          if (fft_done) begin
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          start    <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage: accepted samples are written verbatim; reset clears the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        output_Re[i] <= '0;
        output_Im[i] <= '0;
      end
    end else if (accept) begin
      output_Re[wr_idx] <= in_Re;
      output_Im[wr_idx] <= in_Im;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader (N=64, LOG2N=6, D_WIDTH=16).
// Accepted samples are pushed to a scoreboard queue with their expected
// storage index; the queue is drained and compared when start is observed.
module tb_fft_input_loader;

  localparam int N  = 64;
  localparam int LG = 6;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_Re;
  logic [DW-1:0] in_Im;
  logic          in_valid;
  logic          in_ready;
  logic          fft_done;
  logic [DW-1:0] output_Re [N-1:0];
  logic [DW-1:0] output_Im [N-1:0];
  logic          start;

  fft_input_loader #(.N(N), .LOG2N(LG), .D_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_Re    (in_Re),
    .in_Im    (in_Im),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fft_done (fft_done),
    .output_Re(output_Re),
    .output_Im(output_Im),
    .start    (start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sb_t;

  sb_t           sb_q [$];
  logic [DW-1:0] exp_re [N];
  logic [DW-1:0] exp_im [N];
  int            checks = 0;
  int            errors = 0;
  int            start_seen = 0;
  int            s0;

  // Count every cycle in which start is high.
  always @(negedge clk) if (start === 1'b1) start_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LG; i++) if (k[i]) r |= (1 << (LG - 1 - i));
    return r;
  endfunction

  function automatic int store_idx(input int k);
`ifdef FFT_IN_BITREV_EN
    return brev(k);
`else
    return k;
`endif
  endfunction

  function automatic int nonzero_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) if (output_Re[i] !== '0 || output_Im[i] !== '0) c++;
    return c;
  endfunction

  function automatic int model_diff_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) if (output_Re[i] !== exp_re[i] || output_Im[i] !== exp_im[i]) c++;
    return c;
  endfunction

  // Drive n samples; re = k when use_k, else re_v. gap toggles in_valid every other cycle.
  task automatic feed(input int n, input bit use_k, input logic [DW-1:0] re_v,
                      input logic [DW-1:0] im_v, input bit gap, input int done_at);
    int  k = 0;
    int  guard = 0;
    bit  tog = 1'b0;
    bit  acc;
    sb_t e;
    while (k < n && guard < 2000) begin
      in_valid = gap ? tog : 1'b1;
      tog      = ~tog;
      in_Re    = use_k ? DW'(k) : re_v;
      in_Im    = im_v;
      fft_done = (k == done_at) ? 1'b1 : 1'b0;
      acc      = in_valid && (in_ready === 1'b1);
      if (acc) begin
        e.idx = store_idx(k);
        e.re  = in_Re;
        e.im  = in_Im;
        sb_q.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    fft_done = 1'b0;
    chk("feed_accept_count", k, n);
  endtask

  task automatic drain_and_check();
    sb_t e;
    int  popped = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      popped++;
      exp_re[e.idx] = e.re;
      exp_im[e.idx] = e.im;
      chk($sformatf("re[%0d]", e.idx), output_Re[e.idx], e.re);
      chk($sformatf("im[%0d]", e.idx), output_Im[e.idx], e.im);
    end
    chk("frame_popped", popped, N);
    chk("frame_vs_model", model_diff_cnt(), 0);
  endtask

  task automatic check_start_pulse(input string tag);
    chk({tag, "_start_hi"}, start, 1'b1);
    chk({tag, "_no_early_start"}, start_seen, s0);
    @(posedge clk); #1;
    chk({tag, "_start_lo"}, start, 1'b0);
    chk({tag, "_start_once"}, start_seen, s0 + 1);
    chk({tag, "_ready_lo"}, in_ready, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      exp_re[i] = '0;
      exp_im[i] = '0;
    end
    rst      = 1'b0;
    in_valid = 1'b1;
    in_Re    = 16'd123;
    in_Im    = 16'd45;
    fft_done = 1'b1;

    // Reset held with traffic present.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_arrays_zero", nonzero_cnt(), 0);
    rst = 1'b1;
    chk("idle_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("fill_ready", in_ready, 1'b1);
    chk("idle_no_write", nonzero_cnt(), 0);
    in_valid = 1'b0;
    fft_done = 1'b0;

    // Frame 1: ramp, back-to-back.
    s0 = start_seen;
    feed(N, 1'b1, '0, '0, 1'b0, -1);
    check_start_pulse("f1");
    drain_and_check();
`ifdef FFT_IN_BITREV_EN
    chk("brev_re32", output_Re[32], 16'd1);
    chk("brev_re1", output_Re[1], 16'd32);
    chk("brev_re63", output_Re[63], 16'd63);
    chk("brev_re0", output_Re[0], 16'd0);
`else
    chk("nat_re1", output_Re[1], 16'd1);
    chk("nat_re32", output_Re[32], 16'd32);
    chk("nat_re63", output_Re[63], 16'd63);
    chk("nat_re0", output_Re[0], 16'd0);
`endif

    // HOLD: traffic must be ignored.
    in_valid = 1'b1;
    in_Re    = 16'hAAAA;
    in_Im    = 16'hAAAA;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_stable", model_diff_cnt(), 0);
    end
    chk("hold_no_start", start_seen, s0 + 1);

    // Release the frame.
    in_valid = 1'b0;
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    chk("done_ready", in_ready, 1'b1);

    // Frame 2: 1/-1 with gaps and a stray fft_done during FILL.
    s0 = start_seen;
    feed(N, 1'b0, 16'h0001, 16'hFFFF, 1'b1, 10);
    check_start_pulse("f2");
    drain_and_check();

    // Partial frame then reset.
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    chk("done2_ready", in_ready, 1'b1);
    s0 = start_seen;
    feed(30, 1'b0, 16'h7777, 16'h7777, 1'b0, -1);
    chk("partial_no_start", start_seen, s0);
    rst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_re[i] = '0;
      exp_im[i] = '0;
    end
    #1;
    chk("midrst_zero", nonzero_cnt(), 0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_start", start, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Frame 3 after reset.
    s0 = start_seen;
    feed(N, 1'b0, 16'h0005, 16'h0005, 1'b0, -1);
    check_start_pulse("f3");
    drain_and_check();
    chk("total_starts", start_seen, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 Parameter N, default 64, points per FFT frame.
REQ-002 Parameter LOG2N, default 6, log2(N); width of the sample counter.
REQ-003 Parameter D_WIDTH, default 16, bits per Re/Im sample (two's complement).
REQ-004 Port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1; reset is asynchronous and active-low.
REQ-006 Port in_Re, input, D_WIDTH, real part of the incoming serial sample.
REQ-007 Port in_Im, input, D_WIDTH, imaginary part of the incoming serial sample.
REQ-008 Port in_valid, input, 1, sample on in_Re/in_Im is valid.
REQ-009 Port in_ready, output, 1, loader accepts a sample this cycle.
REQ-010 Port fft_done, input, 1, downstream Butterfly has finished with the current frame.
REQ-011 Port output_Re, output, D_WIDTH x N unpacked array [N-1:0], real frame to Butterfly input_Re.
REQ-012 Port output_Im, output, D_WIDTH x N unpacked array [N-1:0], imaginary frame to Butterfly input_Im.
REQ-013 Port start, output, 1, registered one-cycle pulse telling Butterfly a full frame is present.

Function
REQ-014 The FSM SHALL have states IDLE, FILL, START, HOLD; IDLE->FILL unconditionally after one cycle.
REQ-015 in_ready SHALL be 1 iff state==FILL; a sample is accepted on a rising edge where in_valid && in_ready.
REQ-016 Each accepted sample SHALL be written unmodified (no scaling, rounding or sign change) to both arrays at index f(wr_cnt), then wr_cnt increments by 1.
REQ-017 wr_cnt SHALL be LOG2N bits; the edge that accepts sample N-1 wraps it to 0 and moves the FSM to START.
REQ-018 In START, start SHALL be 1 for exactly one cycle, i.e. the cycle after the edge accepting the Nth sample; FSM then moves to HOLD.
REQ-019 In HOLD, output arrays SHALL be stable and in_valid ignored; fft_done==1 moves FSM to FILL on the next edge.
REQ-020 fft_done SHALL be ignored in IDLE, FILL and START.
REQ-021 In FILL, entries not yet rewritten SHALL keep their previous-frame values; output arrays are guaranteed coherent only from START through HOLD.
REQ-022 in_valid low in FILL SHALL stall the counter with no write; gaps of any length are allowed.

Reset
REQ-023 While rst==0: state IDLE, wr_cnt 0, every output_Re/output_Im entry 0, start 0, in_ready 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, filling restarts at sample index 0.
REQ-025 in_ready SHALL first be 1 in the second cycle after rst deasserts (IDLE then FILL).

Configuration
REQ-026 Macro FFT_IN_BITREV_EN defined: f(k) = LOG2N-bit bit reversal of k (decimation-in-time order for Butterfly).
REQ-027 Macro FFT_IN_BITREV_EN undefined: f(k) = k (natural order; reordering done by a separate sorter stage).

Verification
REQ-028 Hold rst=0 with in_valid=1 -> all outputs 0, start 0, in_ready 0; release -> in_ready=1 two cycles later, nothing written before.
REQ-029 FFT_IN_BITREV_EN on, feed in_Re=k, in_Im=0 for k=0..63 back-to-back -> output_Re[32]=1, output_Re[1]=32, output_Re[63]=63, output_Re[0]=0, all output_Im=0; start high exactly one cycle, the cycle after the 64th handshake.
REQ-030 FFT_IN_BITREV_EN off, same stimulus -> output_Re[k]=k for all k; start timing identical.
REQ-031 in_valid toggled every other cycle -> exactly 64 samples accepted, start after 64th; in HOLD drive in_valid=1, in_Re=16'hAAAA for 20 cycles -> no entry changes, in_ready=0.
REQ-032 In HOLD pulse fft_done -> in_ready=1 next cycle; second frame of in_Re=16'h0001, in_Im=16'hFFFF -> all entries 1 / -1, second start pulse; fft_done pulsed during FILL -> no effect.
REQ-033 Assert rst after 30 samples, release, feed 64 samples of 16'h0005 -> all entries 5, single start pulse, no stale data.
